// File: rtl/game_round_pkg.sv
// rtl/game_round_pkg.sv - shared state encoding and constants for the match sequencer
package game_round_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLAY,
        ST_PAUSE,
        ST_SCORE,
        ST_OVER
    } state_t;

    localparam logic [1:0] LEVEL_MAX  = 2'd3;
    localparam int         STREAK_LEN = 2;

    // Speed level never wraps past the top level.
    function automatic logic [1:0] level_inc(input logic [1:0] lvl);
        return (lvl == LEVEL_MAX) ? lvl : lvl + 2'd1;
    endfunction

endpackage

// File: rtl/game_round_timer.sv
// rtl/game_round_timer.sv - end-of-round pause down-counter
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : start a pause of TIMER_CYCLES cycles
//   running    : high for exactly TIMER_CYCLES cycles after load
//   done       : one-cycle pulse in the last running cycle (count == 0)
module game_round_timer #(
    parameter int TIMER_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic running,
    output logic done
);

    localparam int TW = $clog2(TIMER_CYCLES);

    logic [TW-1:0] count;

    assign done = running && (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            running <= 1'b0;
        end else if (load) begin
            count   <= TW'(TIMER_CYCLES - 1);
            running <= 1'b1;
        end else if (running) begin
            if (count == '0) begin
                running <= 1'b0;
            end else begin
                count <= count - TW'(1);
            end
        end
    end

endmodule

// File: rtl/game_round_sequencer.sv
// rtl/game_round_sequencer.sv - match-level controller above the game master
//   clk, rst_n                : clock, asynchronous active-low reset
//   start_key                 : debounced level, rising edge starts a match
//   end_of_game_timer_start   : end-of-round pulse from the game master
//   game_won                  : round outcome level from the game master
//   end_of_game_timer_running : pause timer active
//   game_enable               : match active, game master may run
//   level, lives              : target speed level, remaining lives
//   hit_count, round_count    : hits and completed rounds this match
//   match_over, match_won     : match finished, and whether it was won
module game_round_sequencer
    import game_round_pkg::*;
#(
    parameter int TIMER_CYCLES = 50_000_000,
    parameter int ROUNDS       = 8,
    parameter int LIVES        = 3,
    parameter int WIN_HITS     = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_key,
    input  logic                          end_of_game_timer_start,
    input  logic                          game_won,
    output logic                          end_of_game_timer_running,
    output logic                          game_enable,
    output logic [1:0]                    level,
    output logic [1:0]                    lives,
    output logic [$clog2(ROUNDS+1)-1:0]   hit_count,
    output logic [$clog2(ROUNDS+1)-1:0]   round_count,
    output logic                          match_over,
    output logic                          match_won
);

    localparam int CW = $clog2(ROUNDS + 1);

    state_t        state;
    logic          start_key_q;
    logic          start_edge;
    logic          timer_load;
    logic          timer_done;
    logic [1:0]    streak;

    logic [CW-1:0] hit_next;
    logic [CW-1:0] round_next;
    logic [1:0]    lives_next;
    logic [1:0]    level_next;
    logic [1:0]    streak_next;
    logic          to_over;

    assign start_edge = start_key & ~start_key_q;
    // Loading only from PLAY makes extra pulses during the pause harmless.
    assign timer_load = (state == ST_PLAY) && end_of_game_timer_start;

    game_round_timer #(
        .TIMER_CYCLES(TIMER_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (timer_load),
        .running(end_of_game_timer_running),
        .done   (timer_done)
    );

    // Score update, only committed at the edge leaving SCORE.
    always_comb begin
        hit_next    = hit_count;
        lives_next  = lives;
        level_next  = level;
        streak_next = streak;
        round_next  = round_count + CW'(1);
        if (game_won) begin
            hit_next = hit_count + CW'(1);
            if (int'(streak) + 1 >= STREAK_LEN) begin
                streak_next = 2'd0;
                level_next  = level_inc(level);
            end else begin
                streak_next = streak + 2'd1;
            end
        end else begin
            lives_next  = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
            streak_next = 2'd0;
        end
        to_over = (lives_next == 2'd0) || (round_next == CW'(ROUNDS));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            start_key_q <= 1'b0;
            game_enable <= 1'b0;
            level       <= 2'd0;
            lives       <= 2'd0;
            streak      <= 2'd0;
            hit_count   <= '0;
            round_count <= '0;
            match_over  <= 1'b0;
            match_won   <= 1'b0;
        end else begin
            start_key_q <= start_key;
            case (state)
                ST_IDLE, ST_OVER: begin
                    if (start_edge) begin
                        state       <= ST_PLAY;
                        game_enable <= 1'b1;
                        match_over  <= 1'b0;
                        match_won   <= 1'b0;
                        lives       <= 2'(LIVES);
                        level       <= 2'd0;
                        streak      <= 2'd0;
                        hit_count   <= '0;
                        round_count <= '0;
                    end
                end
                ST_PLAY: begin
                    if (end_of_game_timer_start) begin
                        state <= ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (timer_done) begin
                        state <= ST_SCORE;
                    end
                end
                ST_SCORE: begin
                    hit_count   <= hit_next;
                    round_count <= round_next;
                    lives       <= lives_next;
                    level       <= level_next;
                    streak      <= streak_next;
                    if (to_over) begin
                        state       <= ST_OVER;
                        game_enable <= 1'b0;
                        match_over  <= 1'b1;
                        match_won   <= (int'(hit_next) >= WIN_HITS);
                    end else begin
                        state <= ST_PLAY;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    game_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_round_sequencer.sv
// tb/tb_game_round_sequencer.sv - directed self-checking bench for game_round_sequencer
module tb_game_round_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start_key;
    logic       end_of_game_timer_start;
    logic       game_won;
    logic       end_of_game_timer_running;
    logic       game_enable;
    logic [1:0] level;
    logic [1:0] lives;
    logic [2:0] hit_count;
    logic [2:0] round_count;
    logic       match_over;
    logic       match_won;

    int tests_run;
    int tests_failed;

    game_round_sequencer #(
        .TIMER_CYCLES(4),
        .ROUNDS      (4),
        .LIVES       (2),
        .WIN_HITS    (3)
    ) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .start_key                (start_key),
        .end_of_game_timer_start  (end_of_game_timer_start),
        .game_won                 (game_won),
        .end_of_game_timer_running(end_of_game_timer_running),
        .game_enable              (game_enable),
        .level                    (level),
        .lives                    (lives),
        .hit_count                (hit_count),
        .round_count              (round_count),
        .match_over               (match_over),
        .match_won                (match_won)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_match(input string tag, input logic en, input logic [1:0] lv,
                             input logic [1:0] lf, input logic [2:0] hc,
                             input logic [2:0] rc, input logic mo, input logic mw);
        chk({tag, ".game_enable"}, 32'(game_enable), 32'(en));
        chk({tag, ".level"},       32'(level),       32'(lv));
        chk({tag, ".lives"},       32'(lives),       32'(lf));
        chk({tag, ".hit_count"},   32'(hit_count),   32'(hc));
        chk({tag, ".round_count"}, 32'(round_count), 32'(rc));
        chk({tag, ".match_over"},  32'(match_over),  32'(mo));
        chk({tag, ".match_won"},   32'(match_won),   32'(mw));
    endtask

    // One round: pulse, 4 pause cycles, SCORE, then the edge leaving SCORE.
    // raise_at >= 0 drives the outcome during that pause cycle, else in SCORE.
    task automatic run_round(input logic won, input int raise_at, input logic extra);
        end_of_game_timer_start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (raise_at == i) game_won = won;
            end_of_game_timer_start = (extra && i == 1);
            chk("pause_running", 32'(end_of_game_timer_running), 32'd1);
            @(negedge clk);
        end
        end_of_game_timer_start = 1'b0;
        chk("score_running", 32'(end_of_game_timer_running), 32'd0);
        chk("score_enable", 32'(game_enable), 32'd1);
        if (raise_at < 0) game_won = won;
        @(negedge clk);
        game_won = 1'b0;
    endtask

    task automatic press_start();
        start_key = 1'b1;
        @(negedge clk);
        start_key = 1'b0;
    endtask

    initial begin
        tests_run               = 0;
        tests_failed            = 0;
        rst_n                   = 1'b0;
        start_key               = 1'b0;
        end_of_game_timer_start = 1'b0;
        game_won                = 1'b0;

        repeat (2) @(negedge clk);
        chk_match("reset", 1'b0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0);
        chk("reset_running", 32'(end_of_game_timer_running), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_enable", 32'(game_enable), 32'd0);

        // Start and pause, then level ramp through four hits.
        press_start();
        chk_match("start", 1'b1, 2'd0, 2'd2, 3'd0, 3'd0, 1'b0, 1'b0);
        run_round(1'b1, -1, 1'b0);
        chk_match("hit1", 1'b1, 2'd0, 2'd2, 3'd1, 3'd1, 1'b0, 1'b0);
        chk("play_running", 32'(end_of_game_timer_running), 32'd0);
        run_round(1'b1, -1, 1'b0);
        chk_match("hit2", 1'b1, 2'd1, 2'd2, 3'd2, 3'd2, 1'b0, 1'b0);
        run_round(1'b1, -1, 1'b0);
        chk_match("hit3", 1'b1, 2'd1, 2'd2, 3'd3, 3'd3, 1'b0, 1'b0);
        run_round(1'b1, -1, 1'b0);
        chk_match("hit4", 1'b0, 2'd2, 2'd2, 3'd4, 3'd4, 1'b1, 1'b1);

        // Timer pulse while OVER must not start a pause.
        end_of_game_timer_start = 1'b1;
        @(negedge clk);
        end_of_game_timer_start = 1'b0;
        chk("over_pulse_running", 32'(end_of_game_timer_running), 32'd0);

        // Lives exhausted.
        press_start();
        chk_match("restart", 1'b1, 2'd0, 2'd2, 3'd0, 3'd0, 1'b0, 1'b0);
        run_round(1'b0, -1, 1'b0);
        chk_match("miss1", 1'b1, 2'd0, 2'd1, 3'd0, 3'd1, 1'b0, 1'b0);
        run_round(1'b0, -1, 1'b0);
        chk_match("miss2", 1'b0, 2'd0, 2'd0, 3'd0, 3'd2, 1'b1, 1'b0);

        // Late collision in pause cycle 3, with an extra timer pulse mid-pause.
        press_start();
        run_round(1'b1, 2, 1'b1);
        chk_match("late_hit", 1'b1, 2'd0, 2'd2, 3'd1, 3'd1, 1'b0, 1'b0);
        @(negedge clk);
        chk("no_second_pause", 32'(end_of_game_timer_running), 32'd0);

        // start_key held high through OVER entry must not restart.
        start_key = 1'b1;
        @(negedge clk);
        chk("start_in_play_ignored_rc", 32'(round_count), 32'd1);
        run_round(1'b0, -1, 1'b0);
        run_round(1'b0, -1, 1'b0);
        chk_match("held_over", 1'b0, 2'd0, 2'd0, 3'd1, 3'd3, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        chk_match("held_stay", 1'b0, 2'd0, 2'd0, 3'd1, 3'd3, 1'b1, 1'b0);
        start_key = 1'b0;
        @(negedge clk);
        press_start();
        chk_match("repress", 1'b1, 2'd0, 2'd2, 3'd0, 3'd0, 1'b0, 1'b0);

        // Asynchronous reset in pause cycle 2.
        run_round(1'b1, -1, 1'b0);
        end_of_game_timer_start = 1'b1;
        @(negedge clk);
        end_of_game_timer_start = 1'b0;
        @(negedge clk);
        chk("pre_reset_running", 32'(end_of_game_timer_running), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_match("async_reset", 1'b0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0);
        chk("async_reset_running", 32'(end_of_game_timer_running), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_reset_idle_enable", 32'(game_enable), 32'd0);
        chk("post_reset_idle_running", 32'(end_of_game_timer_running), 32'd0);
        press_start();
        chk_match("post_reset_start", 1'b1, 2'd0, 2'd2, 3'd0, 3'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/game_round_sequencer.md
# game_round_sequencer

Match-level controller above the game master FSM. Owns the end-of-game pause timer, samples the round outcome, keeps hit/miss/lives/round counts and raises the target speed level on hit streaks. It gates the game master with `game_enable`, so the game runs only inside an active match.

## Interface
Parameters:
- `TIMER_CYCLES`, 50_000_000: pause length in clk cycles after each round; must be ≥ 2.
- `ROUNDS`, 8: rounds per match; must be ≥ 1.
- `LIVES`, 3: misses allowed per match; must be 1..3.
- `WIN_HITS`, 5: hits needed for `match_won`.

Ports (widths: CW = $clog2(ROUNDS+1), TW = $clog2(TIMER_CYCLES)):
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_key` in 1: synchronous, debounced level. Its rising edge starts a match.
- `end_of_game_timer_start` in 1: one-cycle pulse from the game master at end of round.
- `game_won` in 1: level from the game master; round outcome.
- `end_of_game_timer_running` out 1: high while the pause timer counts.
- `game_enable` out 1: high while a match is active. Top level holds the game master idle when low.
- `level` out 2: target speed level, 0..3, for target dxy selection.
- `lives` out 2: remaining lives.
- `hit_count` out CW: hits this match.
- `round_count` out CW: completed rounds this match.
- `match_over` out 1: match finished.
- `match_won` out 1: valid while `match_over` is high.

## Operation
States: IDLE, PLAY, PAUSE, SCORE, OVER.
- Start edge detection: `start_edge = start_key & ~start_key_q`, using a registered copy of `start_key`.
- **IDLE**
  - `game_enable` = 0.
  - On `start_edge`: go to PLAY. Load `lives` = LIVES. Clear `hit_count`, `round_count`, `level` and the streak counter.
- **PLAY**
  - `game_enable` = 1.
  - On `end_of_game_timer_start`: go to PAUSE and load timer = TIMER_CYCLES−1.
- **PAUSE**
  - `end_of_game_timer_running` = 1. Timer decrements each cycle.
  - Timer == 0: go to SCORE.
  - Further timer_start pulses are ignored.
- **SCORE**: single cycle, `game_enable` = 1. `game_won` is sampled in this cycle.
  - Hit (`game_won` = 1): `hit_count`++ and streak++. When streak reaches 2, reset streak to 0 and increment `level`, saturating at 3.
  - Miss (`game_won` = 0): `lives`−−, streak = 0.
  - Always: `round_count`++.
  - Go to OVER if lives after update == 0 or round_count after update == ROUNDS; otherwise go to PLAY.
- **OVER**
  - `game_enable` = 0, `match_over` = 1.
  - `match_won` = (hit_count ≥ WIN_HITS), registered on entry.
  - On `start_edge`: same action as from IDLE, then go to PLAY.
- Ignored inputs:
  - `start_edge` in PLAY, PAUSE and SCORE.
  - `end_of_game_timer_start` in IDLE, OVER and SCORE.

## Timing
- Reset (rst_n low, any state, including mid-pause):
  - State = IDLE, timer = 0, `start_key_q` = 0.
  - All outputs = 0, including `lives` and `level`.
- Timer pulse at edge E: `end_of_game_timer_running` is high from E+1 through E+TIMER_CYCLES, i.e. exactly TIMER_CYCLES cycles.
- SCORE is the first cycle with `end_of_game_timer_running` low. `game_won` is still valid then, because the game master clears it only two cycles later. This also captures collisions that occur during the pause.
- Counter outputs update at the edge leaving SCORE.
- `start_key` held high across OVER entry does not restart the match; a new rising edge is required.
- Counters never wrap: `hit_count` and `round_count` ≤ ROUNDS, `lives` ≥ 0, `level` ≤ 3.

## Structure
- Package `game_round_pkg`: state enum (`ST_IDLE` … `ST_OVER`), `LEVEL_MAX = 2'd3`, `STREAK_LEN = 2`.
- Sub-module `game_round_timer`:
  - Inputs: clk, rst_n, `load`.
  - Outputs: `running`, `done`.
  - Down-counter parameterised by TIMER_CYCLES; `done` is a one-cycle pulse when the count reaches 0.
- Remaining logic is the FSM and counters in the top module.

## Test plan
All scenarios use TIMER_CYCLES=4, ROUNDS=4, LIVES=2, WIN_HITS=3.
- **Start and pause.** Reset, then pulse start_key. Then: game_enable=1 and lives=2. Pulse timer_start → running high for exactly 4 cycles. game_won=1 in SCORE → hit_count=1, round_count=1, back to PLAY.
- **Level ramp.** 4 consecutive hits → level goes 0,0,1,1,2. After round 4: match_over=1, match_won=1, game_enable=0.
- **Lives exhausted.** Two misses → lives=0, match_over=1, match_won=0 after round 2.
- **Late collision.** game_won rises during PAUSE cycle 3 → counted as a hit.
- **Ignored inputs.** Extra timer_start during PAUSE → pause length unchanged. start_key held high through OVER → no restart. Then release and re-press → new match with counters cleared.
- **Reset mid-pause.** rst_n low in PAUSE cycle 2 → all outputs 0 and state IDLE immediately (asynchronous).
